// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: ALU control encodings
// used by the multiply/divide unit and its sequencer state type.
package mips_pkg;

    // ALU decoder encodings that route an instruction to the mul/div unit
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    // Sequencer states of the iterative multiply/divide unit
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/abs_neg.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes (negate when the sign bit is set) and to re-apply the
// result sign after the unsigned iteration.
module abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    // Negate on request; 0x80..0 maps to itself, which is the correct
    // unsigned magnitude of the most negative value
    assign o_val = i_neg ? (~i_val + WIDTH'(1'b1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage iterative signed multiply/divide unit owning HI/LO.
// MULT uses shift-add and DIV uses restoring division, both on operand
// magnitudes, one bit per cycle; signs are re-applied in the FIX state.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic             hien,
    input  logic             loen,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Sequencer state
    muldiv_state_t       r_state;
    logic [CW-1:0]       r_count;

    // Operation context latched on accept
    logic [WIDTH-1:0]    r_a;          // original dividend, returned as HI on divide-by-zero
    logic [WIDTH-1:0]    r_operand;    // |a| for MULT (multiplicand), |b| for DIV (divisor)
    logic [2*WIDTH-1:0]  r_acc;        // {upper, lower} working accumulator
    logic                r_op_div;
    logic                r_hien;
    logic                r_loen;
    logic                r_sign_a;
    logic                r_sign_b;
    logic                r_div_zero;

    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic                w_is_div;
    logic                w_accept;

    logic [WIDTH:0]      w_mul_sum;
    logic [2*WIDTH-1:0]  w_mul_next;
    logic [WIDTH:0]      w_rem_shift;
    logic                w_div_ge;
    logic [WIDTH-1:0]    w_rem_sub;
    logic [2*WIDTH-1:0]  w_div_next;
    logic [2*WIDTH-1:0]  w_step;

    logic                w_sign_diff;
    logic                w_lo_zero;
    logic                w_hi_neg;
    logic [WIDTH-1:0]    w_fix_hi;
    logic [WIDTH-1:0]    w_fix_lo;
    logic [WIDTH-1:0]    w_res_hi;
    logic [WIDTH-1:0]    w_res_lo;

    // Operand magnitudes
    abs_neg #(.WIDTH(WIDTH)) u_abs_a (.i_neg(a[WIDTH-1]), .i_val(a), .o_val(w_mag_a));
    abs_neg #(.WIDTH(WIDTH)) u_abs_b (.i_neg(b[WIDTH-1]), .i_val(b), .o_val(w_mag_b));

    assign w_is_div = (alucontrol == ALU_DIV);
    assign w_accept = (r_state == IDLE) && start && (hien | loen) &&
                      ((alucontrol == ALU_MULT) || w_is_div);

    // One shift-add multiply step: add multiplicand into the upper half when
    // the current multiplier bit is set, then shift the whole accumulator right
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits, record quotient bit
    assign w_rem_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = w_rem_shift[WIDTH] || (w_rem_shift[WIDTH-1:0] >= r_operand);
    assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_operand;
    assign w_div_next  = {(w_div_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_step = r_op_div ? w_div_next : w_mul_next;

    // Sign fix. The 2W-bit product is negated half by half: LO is a plain
    // negate, HI takes the borrow only when LO is zero, otherwise it is ~HI.
    // For DIV, LO (quotient) follows the operand sign difference and HI
    // (remainder) follows the dividend sign.
    assign w_sign_diff = r_sign_a ^ r_sign_b;
    assign w_lo_zero   = (r_acc[WIDTH-1:0] == '0);
    assign w_hi_neg    = r_op_div ? r_sign_a : (w_sign_diff && w_lo_zero);

    abs_neg #(.WIDTH(WIDTH)) u_fix_lo (.i_neg(w_sign_diff), .i_val(r_acc[WIDTH-1:0]),       .o_val(w_fix_lo));
    abs_neg #(.WIDTH(WIDTH)) u_fix_hi (.i_neg(w_hi_neg),    .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_fix_hi));

    // Final HI/LO values presented to the FIX write
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch
        w_res_hi = w_fix_hi;
        w_res_lo = w_fix_lo;
        if (r_div_zero) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else if (!r_op_div && w_sign_diff && !w_lo_zero) begin
            w_res_hi = ~r_acc[2*WIDTH-1:WIDTH];
        end
    end

    // Sequencer with registered busy/done and the HI/LO architectural registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        busy    <= 1'b1;
                        r_count <= '0;
                        r_state <= (w_is_div && (b == '0)) ? FIX : RUN;
                    end
                end
                RUN: begin
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (r_hien) hi <= w_res_hi;
                    if (r_loen) lo <= w_res_lo;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand latch and iterative accumulator
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; they are always loaded on accept before the sequencer reads them
        if (w_accept) begin
            r_a        <= a;
            r_op_div   <= w_is_div;
            r_hien     <= hien;
            r_loen     <= loen;
            r_sign_a   <= a[WIDTH-1];
            r_sign_b   <= b[WIDTH-1];
            r_div_zero <= w_is_div && (b == '0);
            r_operand  <= w_is_div ? w_mag_b : w_mag_a;
            r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        end else if (r_state == RUN) begin
            r_acc <= w_step;
        end
    end

endmodule
